// File: rtl/sm4_key_expand.sv
// SM4 key-expansion engine: turns a 128-bit master key into round keys rk0..rk31,
// one per cycle, on a valid/ready stream. Build macro SM4_KEY_STORE_EN adds a
// 32x32 round-key register file with a registered read port.
module sm4_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [31:0]  rk_out,
    output logic [4:0]   rk_idx,
    output logic         busy,
    output logic         done
`ifdef SM4_KEY_STORE_EN
    ,
    input  logic [4:0]   rk_rd_addr,
    output logic [31:0]  rk_rd_data
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sboxLookup(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // CK byte j of round i is ((4i + j) * 7) mod 256; {i, j} is exactly 4i + j.
    function automatic logic [7:0] ckByte(input logic [4:0] i, input logic [1:0] j);
        logic [7:0] n;
        n = {1'b0, i, j};
        return n * 8'd7;
    endfunction

    state_t             state_q, state_d;
    logic [3:0][31:0]   window_q;
    logic [4:0]         count_q;
    logic [31:0]        rkOut_q;
    logic [4:0]         rkIdx_q;
    logic               rkValid_q, rkValid_d;
    logic               done_q, done_d;
    logic               compute;
    logic               keyFire;
    logic               xfer;
    logic               slotFree;
    logic [31:0]        ckWord;
    logic [31:0]        mixIn;
    logic [31:0]        tauOut;
    logic [31:0]        lOut;
    logic [31:0]        rkNext;

    assign keyFire  = key_valid & (state_q == IDLE);
    assign xfer     = rkValid_q & rk_ready;
    assign slotFree = ~rkValid_q | rk_ready;

    // Round function: XOR3 with CK, four S-box lookups, L' diffusion, XOR with K_i.
    always_comb begin
        ckWord = {ckByte(count_q, 2'd0), ckByte(count_q, 2'd1),
                  ckByte(count_q, 2'd2), ckByte(count_q, 2'd3)};
        mixIn  = window_q[1] ^ window_q[2] ^ window_q[3] ^ ckWord;
        tauOut = {sboxLookup(mixIn[31:24]), sboxLookup(mixIn[23:16]),
                  sboxLookup(mixIn[15:8]),  sboxLookup(mixIn[7:0])};
        lOut   = tauOut ^ {tauOut[18:0], tauOut[31:19]} ^ {tauOut[8:0], tauOut[31:9]};
        rkNext = window_q[0] ^ lOut;
    end

    // FSM next state plus the compute strobe, valid flag and done pulse.
    always_comb begin
        state_d   = state_q;
        compute   = 1'b0;
        rkValid_d = rkValid_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) state_d = LOAD;
            end
            LOAD: begin
                compute = slotFree;
                state_d = RUN;
            end
            RUN: begin
                compute = slotFree;
                if (slotFree && count_q == 5'd31) state_d = DRAIN;
            end
            DRAIN: begin
                if (xfer) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (compute) rkValid_d = 1'b1;
        else if (xfer) rkValid_d = 1'b0;
    end

    // State register and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rkValid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rkValid_q <= rkValid_d;
            done_q    <= done_d;
        end
    end

    // Key window, round counter and registered round-key output; all hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q <= '0;
            count_q  <= 5'd0;
            rkOut_q  <= 32'd0;
            rkIdx_q  <= 5'd0;
        end else if (keyFire) begin
            window_q <= {key_in[31:0] ^ FK3, key_in[63:32] ^ FK2,
                         key_in[95:64] ^ FK1, key_in[127:96] ^ FK0};
            count_q  <= 5'd0;
        end else if (compute) begin
            window_q <= {rkNext, window_q[3], window_q[2], window_q[1]};
            rkOut_q  <= rkNext;
            rkIdx_q  <= count_q;
            if (count_q != 5'd31) count_q <= count_q + 5'd1;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rk_valid  = rkValid_q;
    assign rk_out    = rkOut_q;
    assign rk_idx    = rkIdx_q;
    assign done      = done_q;

`ifdef SM4_KEY_STORE_EN
    logic [31:0] store_q [32];
    logic [31:0] rdData_q;

    // Capture every round key as it is handed downstream.
    always_ff @(posedge clk) begin
        if (xfer) store_q[rkIdx_q] <= rkOut_q;
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdData_q <= 32'd0;
        else        rdData_q <= store_q[rk_rd_addr];
    end

    assign rk_rd_data = rdData_q;
`endif

endmodule
